// File: rtl/aes_pkg.sv
// AES-128 shared types, constants and byte helpers for the inverse cipher core.
package aes_pkg;
  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_block_t;

  localparam int unsigned NUM_ROUNDS = 10;

  typedef enum logic [1:0] {ST_IDLE, ST_KEYEXP, ST_ROUND, ST_OUT} core_state_t;

  localparam byte_t RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // Byte 0 of each table sits in the top bits; index by {~b, 3'b000}.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [2047:0] INV_SBOX_TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

  function automatic byte_t sbox(input byte_t b);
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic byte_t inv_sbox(input byte_t b);
    return INV_SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/aes_key_scheduling.sv
// One AES-128 key expansion step: next round key from the previous one and its rcon.
module aes_key_scheduling import aes_pkg::*; (
  input  aes_block_t prev_key,
  input  byte_t      rcon,
  output aes_block_t next_key
);
  aes_word_t w0, w1, w2, w3, temp, n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = prev_key;
  assign temp = {sbox(w3[23:16]) ^ rcon, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
  assign n0 = w0 ^ temp;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};
endmodule

// File: rtl/inv_aes_mixw.sv
// InvMixColumns on one 32-bit column; row 0 is the most significant byte.
module inv_aes_mixw import aes_pkg::*; (
  input  aes_word_t col,
  output aes_word_t mixed
);
  byte_t m9 [4];
  byte_t m11 [4];
  byte_t m13 [4];
  byte_t m14 [4];

  for (genvar i = 0; i < 4; i++) begin : g_mul
    byte_t a, x2, x4, x8;
    assign a  = col[31-8*i -: 8];
    assign x2 = xtime(a);
    assign x4 = xtime(x2);
    assign x8 = xtime(x4);
    assign m9[i]  = x8 ^ a;
    assign m11[i] = x8 ^ x2 ^ a;
    assign m13[i] = x8 ^ x4 ^ a;
    assign m14[i] = x8 ^ x4 ^ x2;
  end

  assign mixed = {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                  m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                  m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                  m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
endmodule

// File: rtl/inv_aes_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
module inv_aes_round import aes_pkg::*; (
  input  aes_block_t state,
  input  aes_block_t rk,
  input  logic       is_last,
  output aes_block_t next_state
);
  aes_block_t shifted, subbed, keyed, mixed;

  // Byte (row r, column c) takes the byte from column (c - r) mod 4 of the same row.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int unsigned DST = 4 * c + r;
      localparam int unsigned SRC = 4 * ((c + 4 - r) % 4) + r;
      assign shifted[127-8*DST -: 8] = state[127-8*SRC -: 8];
    end
  end

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    inv_aes_sbox u_sbox (.val(shifted[127-8*i -: 8]), .sub(subbed[127-8*i -: 8]));
  end

  assign keyed = subbed ^ rk;

  for (genvar c = 0; c < 4; c++) begin : g_mix
    inv_aes_mixw u_mixw (.col(keyed[127-32*c -: 32]), .mixed(mixed[127-32*c -: 32]));
  end

  assign next_state = is_last ? keyed : mixed;
endmodule

// File: rtl/inv_aes_sbox.sv
// Single-byte AES inverse substitution.
module inv_aes_sbox import aes_pkg::*; (
  input  byte_t val,
  output byte_t sub
);
  assign sub = inv_sbox(val);
endmodule

// File: rtl/inv_aes_cbc_core.sv
// Iterative AES-128 decryptor with cached round keys, UNROLL rounds per clock and optional CBC.
module inv_aes_cbc_core import aes_pkg::*; #(
  parameter int unsigned UNROLL = 1,
  parameter bit          CBC_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         key_valid_in,
  output logic         key_ready_out,
  input  logic [127:0] key_in,
  input  logic         iv_valid_in,
  input  logic [127:0] iv_in,
  input  logic         data_valid_in,
  output logic         data_ready_out,
  input  logic [127:0] data_in,
  output logic         res_valid_out,
  input  logic         res_ready_in,
  output logic [127:0] res_dec_out
);
  core_state_t fsm;
  aes_block_t  rk [NUM_ROUNDS+1];
  aes_block_t  blk, chain, ks_next;
  aes_block_t  stage [UNROLL+1];
  logic        key_loaded, iv_act, accept, last_step;
  logic [3:0]  kcnt, r_q;

  assign iv_act         = CBC_EN && iv_valid_in;
  assign key_ready_out  = (fsm == ST_IDLE);
  assign data_ready_out = key_loaded && !key_valid_in && !iv_act &&
                          ((fsm == ST_IDLE) || ((fsm == ST_OUT) && res_ready_in));
  assign accept         = data_valid_in && data_ready_out;
  assign last_step      = (r_q == 4'(UNROLL - 1));

  aes_key_scheduling u_ks (.prev_key(rk[kcnt - 4'd1]), .rcon(RCON[kcnt]), .next_key(ks_next));

  // Round u of a step uses key index r_q - u; the final round (index 0) skips InvMixColumns.
  assign stage[0] = blk;
  for (genvar u = 0; u < UNROLL; u++) begin : g_round
    logic [3:0] ridx;
    assign ridx = r_q - 4'(u);
    inv_aes_round u_round (
      .state(stage[u]), .rk(rk[ridx]), .is_last(ridx == 4'd0), .next_state(stage[u+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (fsm == ST_IDLE && key_valid_in) rk[0] <= key_in;
      else if (fsm == ST_KEYEXP)          rk[kcnt] <= ks_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm           <= ST_IDLE;
      key_loaded    <= 1'b0;
      res_valid_out <= 1'b0;
      res_dec_out   <= '0;
      kcnt          <= 4'd1;
      r_q           <= 4'd9;
      blk           <= '0;
    end else begin
      unique case (fsm)
        ST_IDLE: begin
          if (key_valid_in) begin
            kcnt       <= 4'd1;
            key_loaded <= 1'b0;
            fsm        <= ST_KEYEXP;
          end else if (accept) begin
            blk <= data_in ^ rk[NUM_ROUNDS];
            r_q <= 4'd9;
            fsm <= ST_ROUND;
          end
        end
        ST_KEYEXP: begin
          if (kcnt == 4'd10) begin
            key_loaded <= 1'b1;
            fsm        <= ST_IDLE;
          end else begin
            kcnt <= kcnt + 4'd1;
          end
        end
        ST_ROUND: begin
          blk <= stage[UNROLL];
          r_q <= r_q - 4'(UNROLL);
          if (last_step) begin
            res_dec_out   <= stage[UNROLL] ^ chain;
            res_valid_out <= 1'b1;
            fsm           <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (res_ready_in) begin
            res_valid_out <= 1'b0;
            if (accept) begin
              blk <= data_in ^ rk[NUM_ROUNDS];
              r_q <= 4'd9;
              fsm <= ST_ROUND;
            end else begin
              fsm <= ST_IDLE;
            end
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

  if (CBC_EN) begin : g_cbc
    aes_block_t chain_q, ct_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        chain_q <= '0;
        ct_q    <= '0;
      end else begin
        if (fsm == ST_IDLE && !key_valid_in && iv_valid_in) chain_q <= iv_in;
        if (fsm == ST_ROUND && last_step)                   chain_q <= ct_q;
        if (accept)                                         ct_q    <= data_in;
      end
    end
    assign chain = chain_q;
  end else begin : g_ecb
    logic unused_iv;
    assign unused_iv = ^iv_in;
    assign chain     = '0;
  end
endmodule

// File: tb/tb_inv_aes_cbc_core.sv
// Directed bench: CBC core (UNROLL=1) plus three ECB cores (UNROLL=1,2,5) on FIPS-197/SP800-38A vectors.
module tb_inv_aes_cbc_core;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_F2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV_F2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT3 = 128'h73bed6b8e3c1743b7116e69e22229516;
  localparam logic [127:0] PT3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] CT4 = 128'h3ff1caa1681fac09120eca307586e1a7;
  localparam logic [127:0] PT4 = 128'hf69f2445df4f9b17ad2b417be66c3710;

  int checks = 0;
  int failures = 0;

  logic         reset, key_valid, key_ready, iv_valid, data_valid, data_ready;
  logic         res_valid, res_ready;
  logic [127:0] key, iv, data, res_dec;

  inv_aes_cbc_core #(.UNROLL(1), .CBC_EN(1'b1)) dut (
    .clk(clk), .reset(reset),
    .key_valid_in(key_valid), .key_ready_out(key_ready), .key_in(key),
    .iv_valid_in(iv_valid), .iv_in(iv),
    .data_valid_in(data_valid), .data_ready_out(data_ready), .data_in(data),
    .res_valid_out(res_valid), .res_ready_in(res_ready), .res_dec_out(res_dec)
  );

  logic         e_kv, e_dv, e_rr;
  logic [127:0] e_key, e_data;
  logic         e_kr [3];
  logic         e_dr [3];
  logic         e_rv [3];
  logic [127:0] e_dec [3];

  for (genvar g = 0; g < 3; g++) begin : g_ecb
    inv_aes_cbc_core #(.UNROLL(g == 0 ? 1 : (g == 1 ? 2 : 5)), .CBC_EN(1'b0)) u_ecb (
      .clk(clk), .reset(reset),
      .key_valid_in(e_kv), .key_ready_out(e_kr[g]), .key_in(e_key),
      .iv_valid_in(1'b0), .iv_in(128'h0),
      .data_valid_in(e_dv), .data_ready_out(e_dr[g]), .data_in(e_data),
      .res_valid_out(e_rv[g]), .res_ready_in(e_rr), .res_dec_out(e_dec[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    key = k; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    repeat (10) tick();
  endtask

  task automatic load_iv(input logic [127:0] v);
    iv = v; iv_valid = 1'b1;
    tick();
    iv_valid = 1'b0;
  endtask

  // Presents a block until accepted (bounded); returns at accept edge + 1.
  task automatic send_block(input logic [127:0] ct, output bit ok);
    ok = 1'b0;
    data = ct; data_valid = 1'b1;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (data_ready) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (ok) tick();
    data_valid = 1'b0;
  endtask

  task automatic wait_res(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (res_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key_valid = 1'b0; iv_valid = 1'b0; data_valid = 1'b0; res_ready = 1'b0;
    key = '0; iv = '0; data = '0;
    e_kv = 1'b0; e_dv = 1'b0; e_rr = 1'b0; e_key = '0; e_data = '0;
    tick(); tick();
    checks++; if (key_ready !== 1'b1) begin failures++; $display("FAIL reset_key_ready got=%b exp=1", key_ready); end
    checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL reset_data_ready got=%b exp=0", data_ready); end
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
    checks++; if (res_dec !== 128'h0) begin failures++; $display("FAIL reset_res_dec got=%h exp=0", res_dec); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ecb_latency();
    int lat [3];
    int exp_lat [3];
    bit early;
    exp_lat = '{10, 5, 2};
    e_key = K_C1; e_kv = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++; if (e_kr[g] !== 1'b1) begin failures++; $display("FAIL ecb%0d_key_ready got=%b exp=1", g, e_kr[g]); end
    end
    tick();
    e_kv = 1'b0;
    early = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (e_dr[0] || e_dr[1] || e_dr[2]) early = 1'b1;
      tick();
    end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL ecb_ready_during_keyexp got=%b exp=0", early); end
    for (int g = 0; g < 3; g++) begin
      checks++; if (e_dr[g] !== 1'b1) begin failures++; $display("FAIL ecb%0d_ready_after_keyexp got=%b exp=1", g, e_dr[g]); end
    end
    e_data = CT_C1; e_dv = 1'b1;
    tick();
    e_dv = 1'b0;
    lat = '{-1, -1, -1};
    for (int k = 1; k <= 20; k++) begin
      tick();
      for (int g = 0; g < 3; g++) if (e_rv[g] && lat[g] < 0) lat[g] = k;
    end
    for (int g = 0; g < 3; g++) begin
      checks++; if (lat[g] !== exp_lat[g]) begin failures++; $display("FAIL ecb%0d_latency got=%0d exp=%0d", g, lat[g], exp_lat[g]); end
      checks++; if (e_dec[g] !== PT_C1) begin failures++; $display("FAIL ecb%0d_plaintext got=%h exp=%h", g, e_dec[g], PT_C1); end
    end
    e_rr = 1'b1;
    tick();
    e_rr = 1'b0;
    for (int g = 0; g < 3; g++) begin
      checks++; if (e_rv[g] !== 1'b0) begin failures++; $display("FAIL ecb%0d_valid_drop got=%b exp=0", g, e_rv[g]); end
    end
  endtask

  task automatic test_cbc();
    bit ok;
    int lat;
    load_key(K_F2);
    load_iv(IV_F2);
    send_block(CT1, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL cbc_accept1 got=%b exp=1", ok); end
    wait_res(lat);
    checks++; if (lat !== 10) begin failures++; $display("FAIL cbc_latency got=%0d exp=10", lat); end
    checks++; if (res_dec !== PT1) begin failures++; $display("FAIL cbc_block1 got=%h exp=%h", res_dec, PT1); end
    consume();
    send_block(CT2, ok);
    wait_res(lat);
    checks++; if (lat !== 10) begin failures++; $display("FAIL cbc_latency2 got=%0d exp=10", lat); end
    checks++; if (res_dec !== PT2) begin failures++; $display("FAIL cbc_block2 got=%h exp=%h", res_dec, PT2); end
    consume();
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    send_block(CT3, ok);
    wait_res(lat);
    checks++; if (res_dec !== PT3) begin failures++; $display("FAIL bp_block3 got=%h exp=%h", res_dec, PT3); end
    data = CT4; data_valid = 1'b1; res_ready = 1'b0;
    #1;
    for (int i = 0; i < 7; i++) begin
      checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid cyc=%0d got=%b exp=1", i, res_valid); end
      checks++; if (res_dec !== PT3) begin failures++; $display("FAIL bp_hold_data cyc=%0d got=%h exp=%h", i, res_dec, PT3); end
      checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL bp_data_ready cyc=%0d got=%b exp=0", i, data_ready); end
      tick();
    end
    res_ready = 1'b1;
    #1;
    checks++; if (data_ready !== 1'b1) begin failures++; $display("FAIL bp_b2b_ready got=%b exp=1", data_ready); end
    tick();
    res_ready = 1'b0; data_valid = 1'b0;
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL bp_valid_after_ready got=%b exp=0", res_valid); end
    wait_res(lat);
    checks++; if (lat !== 10) begin failures++; $display("FAIL bp_b2b_latency got=%0d exp=10", lat); end
    checks++; if (res_dec !== PT4) begin failures++; $display("FAIL bp_block4 got=%h exp=%h", res_dec, PT4); end
    consume();
  endtask

  task automatic test_key_priority();
    int cnt;
    int lat;
    logic [127:0] exp_pt;
    exp_pt = PT_C1 ^ CT4;
    key = K_C1; key_valid = 1'b1; data = CT_C1; data_valid = 1'b1;
    #1;
    checks++; if (key_ready !== 1'b1) begin failures++; $display("FAIL prio_key_ready got=%b exp=1", key_ready); end
    checks++; if (data_ready !== 1'b0) begin failures++; $display("FAIL prio_data_blocked got=%b exp=0", data_ready); end
    tick();
    key_valid = 1'b0;
    checks++; if (key_ready !== 1'b0) begin failures++; $display("FAIL prio_keyexp_key_ready got=%b exp=0", key_ready); end
    cnt = -1;
    for (int k = 0; k <= 20; k++) begin
      if (data_ready) begin
        cnt = k;
        break;
      end
      tick();
    end
    checks++; if (cnt !== 10) begin failures++; $display("FAIL prio_keyexp_cycles got=%0d exp=10", cnt); end
    tick();
    data_valid = 1'b0;
    wait_res(lat);
    checks++; if (lat !== 10) begin failures++; $display("FAIL prio_latency got=%0d exp=10", lat); end
    checks++; if (res_dec !== exp_pt) begin failures++; $display("FAIL prio_reload_result got=%h exp=%h", res_dec, exp_pt); end
    consume();
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int lat;
    send_block(CT_C1, ok);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", res_valid); end
    checks++; if (key_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_key_ready got=%b exp=1", key_ready); end
    data = CT_C1; data_valid = 1'b1;
    #1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (data_ready || res_valid) seen = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rst_mid_no_key_activity got=%b exp=0", seen); end
    load_key(K_C1);
    send_block(CT_C1, ok);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL rst_mid_reload_accept got=%b exp=1", ok); end
    wait_res(lat);
    checks++; if (lat !== 10) begin failures++; $display("FAIL rst_mid_latency got=%0d exp=10", lat); end
    checks++; if (res_dec !== PT_C1) begin failures++; $display("FAIL rst_mid_chain_cleared got=%h exp=%h", res_dec, PT_C1); end
    consume();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ecb_latency();
    test_cbc();
    test_backpressure();
    test_key_priority();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
